pipelined_prefix_adder: RTL and testbench

PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

---
 rtl/pipelined_prefix_adder.sv | 178 +++++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_adder.sv
// rtl/pipelined_prefix_adder.sv - Kogge-Stone prefix adder with optional approximate LSB segment
module pipelined_prefix_adder #(
  parameter int WIDTH       = 16,
  parameter int VALENCY     = 2,
  parameter int PIPE        = 1,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Number of prefix levels: smallest n with VALENCY**n >= w.
  function automatic int calc_levels(input int w, input int v);
    int span;
    int n;
    span = 1;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (span < w) begin
        span = span * v;
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int L  = calc_levels(WIDTH, VALENCY);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("pipelined_prefix_adder: WIDTH must be in 2..64");
  end
  if (VALENCY != 2 && VALENCY != 4) begin : g_bad_valency
    $error("pipelined_prefix_adder: VALENCY must be 2 or 4");
  end
  if (PIPE != 0 && PIPE != 1) begin : g_bad_pipe
    $error("pipelined_prefix_adder: PIPE must be 0 or 1");
  end
  if (APPROX_BITS < 0 || APPROX_BITS > WIDTH - 1) begin : g_bad_approx
    $error("pipelined_prefix_adder: APPROX_BITS must be in 0..WIDTH-1");
  end

  logic             enable;
  logic             approx_lo;
  logic [WIDTH-1:0] pre_g;
  logic [WIDTH-1:0] pre_p;
  logic [WIDTH-1:0] pre_h;
  logic             pre_c;

  // lvl_*[0] is the preprocessed operand set; lvl_*[l] is the output of prefix level l.
  logic [WIDTH-1:0] lvl_g [0:L];
  logic [WIDTH-1:0] lvl_p [0:L];
  logic [WIDTH-1:0] src_g;
  logic [WIDTH-1:0] src_p;
  logic             grp_g;
  logic             grp_p;
  int               span;
  int               pos;

  // Stage s holds the result of level s (stage 0 = preprocessed operands).
  logic [WIDTH-1:0] stg_g [0:L-1];
  logic [WIDTH-1:0] stg_p [0:L-1];
  logic [WIDTH-1:0] stg_h [0:L-1];
  logic             stg_c [0:L-1];
  logic             stg_v [0:L-1];

  logic [WIDTH-1:0] fin_h;
  logic             fin_c;
  logic             fin_v;

  // One global advance: every stage moves only when the output register can move.
  assign enable   = out_ready | ~out_valid;
  assign in_ready = enable;

  // Generate/propagate/half-sum; approximate low bits become OR with no carry chain,
  // except bit k-1 whose AND injects the carry into bit k.
  always_comb begin
    approx_lo = approx_en && (APPROX_BITS > 0);
    pre_c     = cin & ~approx_lo;
    pre_g     = '0;
    pre_p     = '0;
    pre_h     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (approx_lo && (i < APPROX_BITS)) begin
        pre_h[i] = a[i] | b[i];
        pre_g[i] = (i == APPROX_BITS - 1) ? (a[i] & b[i]) : 1'b0;
        pre_p[i] = 1'b0;
      end else begin
        pre_h[i] = a[i] ^ b[i];
        pre_g[i] = a[i] & b[i];
        pre_p[i] = a[i] ^ b[i];
      end
    end
    pre_g[0] = pre_g[0] | (pre_p[0] & pre_c);
  end

  // Prefix levels: each bit combines VALENCY groups spaced VALENCY**(l-1) apart.
  always_comb begin
    lvl_g[0] = pre_g;
    lvl_p[0] = pre_p;
    span     = 1;
    src_g    = '0;
    src_p    = '0;
    grp_g    = 1'b0;
    grp_p    = 1'b1;
    pos      = 0;
    for (int l = 1; l <= L; l++) begin
      src_g = (PIPE != 0) ? stg_g[l-1] : lvl_g[l-1];
      src_p = (PIPE != 0) ? stg_p[l-1] : lvl_p[l-1];
      for (int i = 0; i < WIDTH; i++) begin
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int j = VALENCY - 1; j >= 0; j--) begin
          pos = i - j * span;
          if (pos >= 0) begin
            grp_g = src_g[pos[IW-1:0]] | (src_p[pos[IW-1:0]] & grp_g);
            grp_p = src_p[pos[IW-1:0]] & grp_p;
          end
        end
        lvl_g[l][i] = grp_g;
        lvl_p[l][i] = grp_p;
      end
      span = span * VALENCY;
    end
  end

  // Pipeline stage registers; only valid bits need reset, data of bubbles is don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < L; s++) begin
        stg_v[s] <= 1'b0;
      end
    end else if (enable) begin
      stg_v[0] <= in_valid;
      stg_g[0] <= lvl_g[0];
      stg_p[0] <= lvl_p[0];
      stg_h[0] <= pre_h;
      stg_c[0] <= pre_c;
      for (int s = 1; s < L; s++) begin
        stg_v[s] <= stg_v[s-1];
        stg_g[s] <= lvl_g[s];
        stg_p[s] <= lvl_p[s];
        stg_h[s] <= stg_h[s-1];
        stg_c[s] <= stg_c[s-1];
      end
    end
  end

  assign fin_v = (PIPE != 0) ? stg_v[L-1] : in_valid;
  assign fin_h = (PIPE != 0) ? stg_h[L-1] : pre_h;
  assign fin_c = (PIPE != 0) ? stg_c[L-1] : pre_c;

  // Output register: carry into bit i is the group generate of bits [i-1:0]; bubbles keep the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (enable) begin
      out_valid <= fin_v;
      if (fin_v) begin
        sum  <= fin_h ^ {lvl_g[L][WIDTH-2:0], fin_c};
        cout <= lvl_g[L][WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb/tb_pipelined_prefix_adder.sv - scoreboard bench for pipelined_prefix_adder
module tb_pipelined_prefix_adder;

  typedef struct {
    logic [15:0] s;
    logic        c;
    bit          chk;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        in_valid1 = 1'b0, in_ready1, cin1 = 1'b0, approx1 = 1'b0;
  logic        out_valid1, out_ready1 = 1'b0, cout1;
  logic [15:0] a1 = '0, b1 = '0, sum1;

  logic        in_valid2 = 1'b0, in_ready2, cin2 = 1'b0, approx2 = 1'b0;
  logic        out_valid2, out_ready2 = 1'b1, cout2;
  logic [15:0] a2 = '0, b2 = '0, sum2;

  exp_t        q1[$];
  exp_t        q2[$];

  logic [15:0] stream_exp [8] = '{16'h0000, 16'h0001, 16'h0004, 16'h0003,
                                  16'h0008, 16'h0005, 16'h000C, 16'h0007};
  logic [15:0] bp_exp [5] = '{16'h0101, 16'h1212, 16'h2323, 16'h3434, 16'h4546};

  pipelined_prefix_adder #(.WIDTH(16), .VALENCY(2), .PIPE(1), .APPROX_BITS(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .approx_en(approx1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1)
  );

  pipelined_prefix_adder #(.WIDTH(16), .VALENCY(4), .PIPE(0), .APPROX_BITS(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .approx_en(approx2),
    .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send1(input logic [15:0] ta, input logic [15:0] tbv, input logic tc, input logic tap,
                       input logic [15:0] es, input logic ec, input bit chk_lat, input bit push);
    exp_t e;
    int   tries;
    @(posedge clk);
    #1;
    a1 = ta; b1 = tbv; cin1 = tc; approx1 = tap; in_valid1 = 1'b1;
    @(negedge clk);
    tries = 0;
    while (!in_ready1 && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (!in_ready1) begin
      total++; bad++;
      $display("FAIL send1_accept in_ready=%b required=1", in_ready1);
    end else if (push) begin
      e.s = es; e.c = ec; e.chk = chk_lat; e.due = cyc + 5;
      q1.push_back(e);
    end
  endtask

  task automatic idle1();
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (((which == 1) ? q1.size() : q2.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk((which == 1) ? "dut1_drain_left" : "dut2_drain_left",
        (which == 1) ? q1.size() : q2.size(), 0);
  endtask

  // Monitor for dut1: pops one expectation per output transfer.
  initial begin : mon1
    exp_t e;
    bit   seen;
    int   seen_cyc;
    seen = 0; seen_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
      end else begin
        if (out_valid1 && !seen) begin
          seen = 1; seen_cyc = cyc;
        end
        if (out_valid1 && out_ready1) begin
          total++;
          if (q1.size() == 0) begin
            bad++;
            $display("FAIL dut1_unexpected actual=%h/%b required=none", sum1, cout1);
          end else begin
            e = q1.pop_front();
            if (sum1 !== e.s || cout1 !== e.c) begin
              bad++;
              $display("FAIL dut1_result actual=%h/%b required=%h/%b", sum1, cout1, e.s, e.c);
            end
            if (e.chk) begin
              total++;
              if (seen_cyc != e.due) begin
                bad++;
                $display("FAIL dut1_latency actual=%0d required=%0d", seen_cyc, e.due);
              end
            end
          end
          seen = 0;
        end
      end
    end
  end

  // Monitor for dut2.
  initial begin : mon2
    exp_t e;
    bit   seen;
    int   seen_cyc;
    seen = 0; seen_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
      end else begin
        if (out_valid2 && !seen) begin
          seen = 1; seen_cyc = cyc;
        end
        if (out_valid2 && out_ready2) begin
          total++;
          if (q2.size() == 0) begin
            bad++;
            $display("FAIL dut2_unexpected actual=%h/%b required=none", sum2, cout2);
          end else begin
            e = q2.pop_front();
            if (sum2 !== e.s || cout2 !== e.c) begin
              bad++;
              $display("FAIL dut2_result actual=%h/%b required=%h/%b", sum2, cout2, e.s, e.c);
            end
            if (e.chk) begin
              total++;
              if (seen_cyc != e.due) begin
                bad++;
                $display("FAIL dut2_latency actual=%0d required=%0d", seen_cyc, e.due);
              end
            end
          end
          seen = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    exp_t        e;
    logic [16:0] t;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid1, 1'b0);
    chk("reset_sum", sum1, 16'h0000);
    chk("reset_cout", cout1, 1'b0);
    chk("reset_in_ready", in_ready1, 1'b1);
    chk("reset_out_valid2", out_valid2, 1'b0);

    out_ready1 = 1'b1;
    send1(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 1);
    send1(16'h0008, 16'h0008, 1'b0, 1'b1, 16'h0018, 1'b0, 1, 1);
    send1(16'h000F, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b0, 1, 1);
    send1(16'h0008, 16'h0008, 1'b0, 1'b0, 16'h0010, 1'b0, 1, 1);
    send1(16'h000F, 16'h0001, 1'b1, 1'b0, 16'h0011, 1'b0, 1, 1);
    send1(16'hFFF8, 16'h0008, 1'b1, 1'b1, 16'h0008, 1'b1, 1, 1);
    idle1();
    drain(1);

    for (int i = 0; i < 8; i++) begin
      send1(16'(i), 16'(i), 1'b0, (i % 2) == 1, stream_exp[i], 1'b0, 1, 1);
    end
    idle1();
    drain(1);

    for (int i = 0; i < 5; i++) begin
      send1(16'(i * 16'h1111), 16'h0101, i == 4, 1'b0, bp_exp[i], 1'b0, i == 0, 1);
    end
    @(posedge clk);
    #1;
    out_ready1 = 1'b0;
    a1 = 16'hAAAA; b1 = 16'h5555; cin1 = 1'b0; approx1 = 1'b0; in_valid1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid1, 1'b1);
      chk("stall_sum", sum1, 16'h0101);
      chk("stall_in_ready", in_ready1, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready1 = 1'b1;
    in_valid1  = 1'b0;
    send1(16'hF000, 16'h1234, 1'b1, 1'b0, 16'h0235, 1'b1, 1, 1);
    idle1();
    drain(1);

    send1(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0);
    send1(16'h3333, 16'h4444, 1'b1, 1'b1, 16'h0000, 1'b0, 0, 0);
    send1(16'h5555, 16'h6666, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid1, 1'b0);
    chk("flush_sum", sum1, 16'h0000);
    chk("flush_in_ready", in_ready1, 1'b1);
    repeat (15) @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      a2 = 16'($urandom);
      b2 = 16'($urandom);
      cin2 = 1'($urandom);
      approx2 = 1'($urandom);
      in_valid2 = ($urandom_range(0, 3) != 0);
      out_ready2 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid2 && in_ready2) begin
        t = {1'b0, a2} + {1'b0, b2} + {16'b0, cin2};
        e.s = t[15:0]; e.c = t[16]; e.chk = 1; e.due = cyc + 1;
        q2.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    in_valid2  = 1'b0;
    out_ready2 = 1'b1;
    drain(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
